// File: rtl/pe_psum_pkg.sv
// Shared psum constants and types for the PE psum datapath and its FIFOs.
package pe_psum_pkg;

    localparam int PSUM_W          = 21;
    localparam int PSUM_FIFO_DEPTH = 4;
    localparam int PSUM_FIFO_AF    = 3;

    typedef logic signed [PSUM_W-1:0] psum_t;

    // Bits needed to count 0..depth inclusive.
    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pe_psum_fifo_ctrl.sv
// Psum FIFO bookkeeping: read/write pointers, authoritative level counter and
// the empty/full/almost-full flags derived from it.
module pe_psum_fifo_ctrl
    import pe_psum_pkg::*;
#(
    parameter int DEPTH     = PSUM_FIFO_DEPTH,
    parameter int AF_THRESH = PSUM_FIFO_AF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    output logic [$clog2(DEPTH)-1:0] wr_ptr_o,
    output logic [$clog2(DEPTH)-1:0] rd_ptr_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     almost_full_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q,  level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_i) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            level_d = level_q + LVL_W'(push_i) - LVL_W'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign wr_ptr_o      = wr_ptr_q;
    assign rd_ptr_o      = rd_ptr_q;
    assign level_o       = level_q;
    assign empty_o       = (level_q == '0);
    assign full_o        = (level_q == LVL_W'(DEPTH));
    assign almost_full_o = (level_q >= LVL_W'(AF_THRESH));

endmodule

// File: rtl/pe_psum_fifo_param.sv
// Parametrised psum FIFO between the PE psum datapath and the cluster psum network.
// Define PE_PSUM_FIFO_BYPASS_EN for combinational fall-through while empty.
module pe_psum_fifo_param
    import pe_psum_pkg::*;
#(
    parameter int DATA_W    = PSUM_W,
    parameter int DEPTH     = PSUM_FIFO_DEPTH,
    parameter int AF_THRESH = PSUM_FIFO_AF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     data_in_valid,
    output logic                     data_in_ready,
    input  logic signed [DATA_W-1:0] data_in,
    output logic                     data_out_valid,
    input  logic                     data_out_ready,
    output logic signed [DATA_W-1:0] data_out,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0]        wr_ptr, rd_ptr;
    logic                     empty, full;
    logic                     push_hs, pop_hs, bypass_xfer;
    logic                     wr_en, rd_en;
    logic signed [DATA_W-1:0] storage_q [DEPTH];

    pe_psum_fifo_ctrl #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH)
    ) u_ctrl (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush),
        .push_i        (wr_en),
        .pop_i         (rd_en),
        .wr_ptr_o      (wr_ptr),
        .rd_ptr_o      (rd_ptr),
        .level_o       (level),
        .empty_o       (empty),
        .full_o        (full),
        .almost_full_o (almost_full)
    );

    // Ready depends only on registered state and flush, never on the consumer.
    assign data_in_ready = ~full & ~flush;

`ifdef PE_PSUM_FIFO_BYPASS_EN
    assign data_out_valid = ~flush & (empty ? data_in_valid : 1'b1);
    assign data_out       = (empty & ~flush) ? data_in : storage_q[rd_ptr];
    // A word that falls through and is consumed the same cycle never touches storage.
    assign bypass_xfer    = empty & push_hs & data_out_ready;
`else
    assign data_out_valid = ~empty & ~flush;
    assign data_out       = storage_q[rd_ptr];
    assign bypass_xfer    = 1'b0;
`endif

    assign push_hs = data_in_valid & data_in_ready;
    assign pop_hs  = data_out_valid & data_out_ready;
    assign wr_en   = push_hs & ~bypass_xfer;
    assign rd_en   = pop_hs & ~bypass_xfer;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (rst) begin
                storage_q[gi] <= '0;
            end else if (wr_en && (wr_ptr == ADDR_W'(gi))) begin
                storage_q[gi] <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_pe_psum_fifo_param.sv
// Directed vector bench for pe_psum_fifo_param (DEPTH=4, AF_THRESH=3, DATA_W=21).
module tb_pe_psum_fifo_param;

    localparam int DATA_W = 21;
    localparam int DEPTH  = 4;
    localparam int AF     = 3;
    localparam int LVL_W  = $clog2(DEPTH) + 1;
`ifdef PE_PSUM_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic                     data_in_valid;
    logic                     data_in_ready;
    logic signed [DATA_W-1:0] data_in;
    logic                     data_out_valid;
    logic                     data_out_ready;
    logic signed [DATA_W-1:0] data_out;
    logic [LVL_W-1:0]         level;
    logic                     almost_full;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pe_psum_fifo_param #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_in        (data_in),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .data_out       (data_out),
        .level          (level),
        .almost_full    (almost_full)
    );

    // Inputs for one cycle and the outputs expected before that cycle's edge.
    typedef struct {
        int                       id;
        logic                     iv;
        logic signed [DATA_W-1:0] din;
        logic                     ordy;
        logic                     fl;
        logic                     e_irdy;
        logic                     e_ovld;
        logic signed [DATA_W-1:0] e_dout;
        int                       e_lvl;
        logic                     e_af;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int id, input logic iv, input int din, input logic ordy,
                       input logic fl, input logic e_irdy, input logic e_ovld,
                       input int e_dout, input int e_lvl, input logic e_af);
        vec_t v;
        v.id = id; v.iv = iv; v.din = DATA_W'(din); v.ordy = ordy; v.fl = fl;
        v.e_irdy = e_irdy; v.e_ovld = e_ovld; v.e_dout = DATA_W'(e_dout);
        v.e_lvl = e_lvl; v.e_af = e_af;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int id, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%0d expected=%0d", name, id, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input int din, input logic ordy, input logic fl);
        data_in_valid  = iv;
        data_in        = DATA_W'(din);
        data_out_ready = ordy;
        flush          = fl;
    endtask

    int w [20];

    initial begin
        rst = 1'b1;
        drive(1'b0, 0, 1'b0, 1'b0);

        // 1: three pushes with consumer stalled, then drain
        add(100, 1,   5, 0, 0, 1, 0,   0, 0, 0);
        add(101, 1,  -7, 0, 0, 1, 1,   5, 1, 0);
        add(102, 1, 100, 0, 0, 1, 1,   5, 2, 0);
        add(103, 0,   0, 0, 0, 1, 1,   5, 3, 1);
        add(104, 0,   0, 1, 0, 1, 1,   5, 3, 1);
        add(105, 0,   0, 1, 0, 1, 1,  -7, 2, 0);
        add(106, 0,   0, 1, 0, 1, 1, 100, 1, 0);
        add(107, 0,   0, 1, 0, 1, 0,   0, 0, 0);
        // 2: fill to DEPTH, push blocked while full, drain in order
        add(200, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        add(201, 1, 2, 0, 0, 1, 1, 1, 1, 0);
        add(202, 1, 3, 0, 0, 1, 1, 1, 2, 0);
        add(203, 1, 4, 0, 0, 1, 1, 1, 3, 1);
        add(204, 1, 5, 0, 0, 0, 1, 1, 4, 1);
        add(205, 0, 0, 1, 0, 0, 1, 1, 4, 1);
        add(206, 0, 0, 1, 0, 1, 1, 2, 3, 1);
        add(207, 0, 0, 1, 0, 1, 1, 3, 2, 0);
        add(208, 0, 0, 1, 0, 1, 1, 4, 1, 0);
        add(209, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        // 3: full with push and pop offered together: only the pop happens
        add(300, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        add(301, 1, 2, 0, 0, 1, 1, 1, 1, 0);
        add(302, 1, 3, 0, 0, 1, 1, 1, 2, 0);
        add(303, 1, 4, 0, 0, 1, 1, 1, 3, 1);
        add(304, 1, 9, 1, 0, 0, 1, 1, 4, 1);
        add(305, 1, 9, 0, 0, 1, 1, 2, 3, 1);
        add(306, 0, 0, 0, 0, 0, 1, 2, 4, 1);
        add(307, 0, 0, 1, 0, 0, 1, 2, 4, 1);
        add(308, 0, 0, 1, 0, 1, 1, 3, 3, 1);
        add(309, 0, 0, 1, 0, 1, 1, 4, 2, 0);
        add(310, 0, 0, 1, 0, 1, 1, 9, 1, 0);
        add(311, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        // 4: one word primed, then 20 push+pop cycles at constant level 1
        w[0] = -1048576;
        for (int k = 1; k < 20; k++) w[k] = k * 37 - 300;
        w[10] = 1048575;
        add(400, 1, 1000, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++)
            add(401 + k, 1, w[k], 1, 0, 1, 1, (k == 0) ? 1000 : w[k-1], 1, 0);
        add(421, 0, 0, 1, 0, 1, 1, w[19], 1, 0);
        add(422, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        // 5: flush at level 3 with a push offered, then flush held two cycles
        add(500, 1, 11, 0, 0, 1, 0, 0, 0, 0);
        add(501, 1, 22, 0, 0, 1, 1, 11, 1, 0);
        add(502, 1, 33, 0, 0, 1, 1, 11, 2, 0);
        add(503, 1, 44, 1, 1, 0, 0, 0, 3, 1);
        add(504, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(505, 1, 55, 1, 1, 0, 0, 0, 0, 0);
        add(506, 1, 66, 1, 1, 0, 0, 0, 0, 0);
        add(507, 0, 0, 1, 0, 1, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_irdy", 0, int'(data_in_ready), 1);
        chk("rst_ovld", 0, int'(data_out_valid), 0);
        chk("rst_dout", 0, int'(data_out), 0);
        chk("rst_lvl",  0, int'(level), 0);
        chk("rst_af",   0, int'(almost_full), 0);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            // With fall-through, an empty FIFO presents the producer's word directly.
            if (BYP && v.e_lvl == 0 && !v.fl && v.iv) begin
                v.e_ovld = 1'b1;
                v.e_dout = v.din;
            end
            @(negedge clk);
            drive(v.iv, int'(v.din), v.ordy, v.fl);
            #1;
            chk("in_ready",  v.id, int'(data_in_ready), int'(v.e_irdy));
            chk("out_valid", v.id, int'(data_out_valid), int'(v.e_ovld));
            chk("level",     v.id, int'(level), v.e_lvl);
            chk("almost_full", v.id, int'(almost_full), int'(v.e_af));
            if (v.e_ovld) chk("data_out", v.id, int'(data_out), int'(v.e_dout));
        end

        // 6: empty FIFO, word offered with consumer ready
        @(negedge clk);
        drive(1'b1, -42, 1'b1, 1'b0);
        #1;
        if (BYP) begin
            chk("byp_ovld", 600, int'(data_out_valid), 1);
            chk("byp_dout", 600, int'(data_out), -42);
        end else begin
            chk("nobyp_ovld", 600, int'(data_out_valid), 0);
        end
        chk("byp_irdy", 600, int'(data_in_ready), 1);
        @(negedge clk);
        drive(1'b0, 0, 1'b1, 1'b0);
        #1;
        if (BYP) begin
            chk("byp_lvl",  601, int'(level), 0);
            chk("byp_ovld", 601, int'(data_out_valid), 0);
        end else begin
            chk("nobyp_lvl",  601, int'(level), 1);
            chk("nobyp_ovld", 601, int'(data_out_valid), 1);
            chk("nobyp_dout", 601, int'(data_out), -42);
        end
        @(negedge clk);
        #1;
        chk("post6_lvl", 602, int'(level), 0);

        // Reset mid-operation discards contents
        @(negedge clk);
        drive(1'b1, 77, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 88, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 0, 1'b0, 1'b0);
        #1;
        chk("pre_rst_lvl", 700, int'(level), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_lvl",  701, int'(level), 0);
        chk("mid_rst_ovld", 701, int'(data_out_valid), 0);
        chk("mid_rst_dout", 701, int'(data_out), 0);
        chk("mid_rst_irdy", 701, int'(data_in_ready), 1);
        chk("mid_rst_af",   701, int'(almost_full), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
